branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage pipelined RV32 core.
- Sits beside the PC and instruction memory in Fetch: it is looked up combinationally with pc_f and supplies a predicted next PC.
- Trained non-speculatively by the Execute stage once a branch/jump resolves.
- Supports bimodal (counters in the BTB entry) or gshare (global-history-indexed PHT) modes, and keeps performance counters.

---
 rtl/branch_predictor.sv | 122 ++++++++++++
 tb/tb_branch_predictor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB-based dynamic branch predictor (bimodal or gshare) with perf counters
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int MODE       = 0,
  parameter int HIST_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] pc_f_i,
  output logic                  predict_taken_f_o,
  output logic [DATA_WIDTH-1:0] predict_target_f_o,
  output logic [HIST_BITS-1:0]  hist_f_o,
  input  logic                  update_en_e_i,
  input  logic [DATA_WIDTH-1:0] pc_e_i,
  input  logic                  branch_e_i,
  input  logic                  jump_e_i,
  input  logic                  taken_e_i,
  input  logic [DATA_WIDTH-1:0] target_e_i,
  input  logic [HIST_BITS-1:0]  hist_e_i,
  input  logic                  mispredict_e_i,
  output logic [31:0]           branch_count_o,
  output logic [31:0]           mispredict_count_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

  // BTB fields, one slot per index
  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    jmp_q;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  // Gshare pattern table and global history
  logic [1:0]            pht_q    [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q;
  logic [31:0]           branch_cnt_q;
  logic [31:0]           mispred_cnt_q;

  logic [IDX_BITS-1:0]   idx_f, idx_e, pht_idx_f, pht_idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic [1:0]            ctr_f;
  logic                  unused_pc_bits;

  // Word-aligned PCs: the two low bits never participate
  assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

  assign idx_f     = pc_f_i[IDX_BITS+1:2];
  assign tag_f     = pc_f_i[DATA_WIDTH-1:IDX_BITS+2];
  assign idx_e     = pc_e_i[IDX_BITS+1:2];
  assign tag_e     = pc_e_i[DATA_WIDTH-1:IDX_BITS+2];
  assign pht_idx_f = idx_f ^ IDX_BITS'(ghr_q);
  assign pht_idx_e = idx_e ^ IDX_BITS'(hist_e_i);

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign ctr_f = (MODE == 1) ? pht_q[pht_idx_f] : ctr_q[idx_f];

  assign predict_taken_f_o  = hit_f && (jmp_q[idx_f] || ctr_f[1]);
  assign predict_target_f_o = hit_f ? target_q[idx_f] : '0;
  assign hist_f_o           = ghr_q;
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // BTB / PHT / GHR training; clear_i wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      jmp_q   <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        pht_q[i]    <= 2'b01;
      end
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (update_en_e_i) begin
      if (hit_e) begin
        if (branch_e_i) begin
          ctr_q[idx_e] <= sat_step(ctr_q[idx_e], taken_e_i);
          jmp_q[idx_e] <= 1'b0;
          if (taken_e_i) target_q[idx_e] <= target_e_i;
        end else if (jump_e_i) begin
          target_q[idx_e] <= target_e_i;
          jmp_q[idx_e]    <= 1'b1;
        end
      end else if (taken_e_i) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= target_e_i;
        jmp_q[idx_e]    <= jump_e_i;
        ctr_q[idx_e]    <= 2'b10;
      end
      if (MODE == 1 && branch_e_i) begin
        pht_q[pht_idx_e] <= sat_step(pht_q[pht_idx_e], taken_e_i);
        ghr_q            <= HIST_BITS'({ghr_q, taken_e_i});
      end
    end
  end

  // Perf counters count every resolved update, including one dropped by clear_i
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (update_en_e_i) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_e_i) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - table/scoreboard bench for branch_predictor (bimodal and gshare instances)
module tb_branch_predictor;

  typedef struct {
    logic        rstn;
    logic        clr;
    logic [1:0]  kind;   // 0 none, 1 branch, 2 jump
    logic        tk;
    logic        mis;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic [3:0]  he;
    logic [31:0] pcf;
    logic        sel;    // 0 bimodal instance, 1 gshare instance
    logic [1:0]  chk;    // bit0 lookup outputs, bit1 perf counters
    logic        etk;
    logic [31:0] etgt;
    logic [3:0]  eh;
    logic [31:0] ebc;
    logic [31:0] emc;
  } vec_t;

  localparam logic [1:0] N = 2'd0, B = 2'd1, J = 2'd2;
  localparam logic [1:0] L = 2'b01, C = 2'b10, LC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc_f = '0;
  logic        upd = 1'b0, br = 1'b0, jp = 1'b0, tk = 1'b0, mis = 1'b0;
  logic [31:0] pc_e = '0, tgt_e = '0;
  logic [3:0]  hist_e = '0;

  logic        bm_tk, gs_tk;
  logic [31:0] bm_tgt, gs_tgt, bm_bc, gs_bc, bm_mc, gs_mc;
  logic [3:0]  bm_h, gs_h;

  int passed = 0;
  int total  = 0;
  int vec_id = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(0), .HIST_BITS(4)) u_bim (
    .clk(clk), .rst_n_i(rst_n), .clear_i(clear), .pc_f_i(pc_f),
    .predict_taken_f_o(bm_tk), .predict_target_f_o(bm_tgt), .hist_f_o(bm_h),
    .update_en_e_i(upd), .pc_e_i(pc_e), .branch_e_i(br), .jump_e_i(jp),
    .taken_e_i(tk), .target_e_i(tgt_e), .hist_e_i(hist_e), .mispredict_e_i(mis),
    .branch_count_o(bm_bc), .mispredict_count_o(bm_mc)
  );

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .MODE(1), .HIST_BITS(4)) u_gsh (
    .clk(clk), .rst_n_i(rst_n), .clear_i(clear), .pc_f_i(pc_f),
    .predict_taken_f_o(gs_tk), .predict_target_f_o(gs_tgt), .hist_f_o(gs_h),
    .update_en_e_i(upd), .pc_e_i(pc_e), .branch_e_i(br), .jump_e_i(jp),
    .taken_e_i(tk), .target_e_i(tgt_e), .hist_e_i(hist_e), .mispredict_e_i(mis),
    .branch_count_o(gs_bc), .mispredict_count_o(gs_mc)
  );

  function automatic vec_t mk(
    input logic rstn, input logic clr, input logic [1:0] kind, input logic t,
    input logic m, input logic [31:0] pce, input logic [31:0] tgt, input logic [3:0] he,
    input logic [31:0] pcf, input logic sel, input logic [1:0] chk, input logic etk,
    input logic [31:0] etgt, input logic [3:0] eh, input logic [31:0] ebc, input logic [31:0] emc);
    vec_t v;
    v.rstn = rstn; v.clr = clr; v.kind = kind; v.tk = t; v.mis = m;
    v.pce = pce; v.tgt = tgt; v.he = he; v.pcf = pcf; v.sel = sel; v.chk = chk;
    v.etk = etk; v.etgt = etgt; v.eh = eh; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
  endtask

  task automatic check_out(input vec_t e, input int id);
    if (e.chk[0]) begin
      cmp("taken",  id, {31'd0, e.sel ? gs_tk : bm_tk}, {31'd0, e.etk});
      cmp("target", id, e.sel ? gs_tgt : bm_tgt, e.etgt);
      cmp("hist",   id, {28'd0, e.sel ? gs_h : bm_h}, {28'd0, e.eh});
    end
    if (e.chk[1]) begin
      cmp("branch_count",     id, e.sel ? gs_bc : bm_bc, e.ebc);
      cmp("mispredict_count", id, e.sel ? gs_mc : bm_mc, e.emc);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst_n  = v.rstn;
    clear  = v.clr;
    upd    = (v.kind != N);
    br     = (v.kind == B);
    jp     = (v.kind == J);
    tk     = v.tk;
    mis    = v.mis;
    pc_e   = v.pce;
    tgt_e  = v.tgt;
    hist_e = v.he;
    pc_f   = v.pcf;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard vec %0d: queue empty", vec_id);
    end else begin
      e = exp_q.pop_front();
      check_out(e, vec_id);
    end
    vec_id++;
  endtask

  initial begin
    // Bimodal: allocation, counter training, alias miss, saturation
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h40,0,LC,0,0,0,0,0));
    tbl.push_back(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,0,0,0,0,0));
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,0,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h40,0,L,0,'h20,0,0,0));
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h80,0,L,0,0,0,0,0));
    tbl.push_back(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,0,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,0,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,0,0,'h40,'h20,0,'h40,0,L,1,'h20,0,0,0));
    tbl.push_back(mk(1,0,B,0,0,'h40,'h20,0,'h40,0,L,0,'h20,0,0,0));
    tbl.push_back(mk(1,0,N,0,0,0,0,0,'h40,0,L,0,'h20,0,0,0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Floor: ten not-taken keep ctr at 00, then 00 -> 01 -> 10
    for (int i = 0; i < 10; i++) apply(mk(1,0,B,0,0,'h40,'h20,0,'h40,0,L,0,'h20,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,0,'h20,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,0,L,0,'h20,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,L,0,'h20,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,0,L,1,'h20,0,0,0));

    // Jump allocation with same-cycle lookup, second index, branch on a jump entry
    apply(mk(1,0,J,1,0,'h100,'h200,0,'h100,0,L,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h100,0,L,1,'h200,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,0,L,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h44,'h88,0,'h44,0,L,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h44,0,L,1,'h88,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h100,0,L,1,'h200,0,0,0));
    apply(mk(1,0,B,0,0,'h100,'h300,0,'h100,0,L,1,'h200,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h100,0,L,0,'h200,0,0,0));

    // Gshare: history build-up, jump leaves history, clear beats update
    apply(mk(0,0,N,0,0,0,0,0,'h40,1,2'b00,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,1,LC,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,1,L,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,1,'h40,1,L,0,'h20,1,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,3,'h40,1,L,0,'h20,3,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,1,L,0,'h20,7,0,0));
    apply(mk(1,0,J,1,0,'h100,'h200,7,'h100,1,L,0,0,7,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h100,1,LC,1,'h200,7,4,0));
    apply(mk(1,1,B,1,0,'h100,'h300,7,'h100,1,L,1,'h200,7,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h100,1,LC,0,0,7,5,0));
    apply(mk(1,0,B,1,0,'h40,'h20,7,'h40,1,L,0,0,7,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,15,'h40,1,L,0,'h20,15,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,1,L,1,'h20,15,0,0));

    // Perf counters, then reset mid-stream with an update in the reset cycle
    apply(mk(0,0,N,0,0,0,0,0,'h40,0,2'b00,0,0,0,0,0));
    apply(mk(1,0,B,1,1,'h40,'h20,0,'h40,0,C,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,2'b00,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,C,0,0,0,2,1));
    apply(mk(1,0,B,1,1,'h40,'h20,0,'h40,0,2'b00,0,0,0,0,0));
    apply(mk(1,0,B,1,0,'h40,'h20,0,'h40,0,C,0,0,0,4,2));
    apply(mk(1,0,N,0,0,0,0,0,'h40,0,LC,1,'h20,0,5,2));
    apply(mk(0,0,B,1,0,'h44,'h88,0,'h40,0,2'b00,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,0,LC,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h44,0,L,0,0,0,0,0));
    apply(mk(1,0,N,0,0,0,0,0,'h40,1,LC,0,0,0,0,0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
